// File: rtl/localization_pkg.sv
// -----------------------------------------------------------------------------
// localization_pkg
// Types and defaults shared by the sound-localization blocks.
//   run_state_t          : run controller states (IDLE, RUN, DRAIN)
//   DEF_SAMPLE_WIDTH     : default width of one signed microphone sample
//   DEF_DATA_WIDTH       : default width of a packed {y, x} direction vector
//   MIC_PX..MIC_NY       : index of each microphone in the per-mic arrays
// -----------------------------------------------------------------------------
package localization_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_DATA_WIDTH   = 2 * DEF_SAMPLE_WIDTH;

  localparam int NUM_MICS = 4;
  localparam int MIC_PX   = 0;
  localparam int MIC_PY   = 1;
  localparam int MIC_NX   = 2;
  localparam int MIC_NY   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } run_state_t;

endpackage

// File: rtl/abs_sat.sv
// -----------------------------------------------------------------------------
// abs_sat
// Combinational magnitude of a signed sample. The most negative code has no
// positive counterpart, so it saturates to the largest positive magnitude.
// The result therefore always fits in W-1 unsigned bits.
//   sample    : signed input sample, W bits
//   magnitude : |sample| saturated, W-1 bits unsigned
// -----------------------------------------------------------------------------
module abs_sat
  import localization_pkg::*;
#(
  parameter int W = DEF_SAMPLE_WIDTH
) (
  input  logic signed [W-1:0] sample,
  output logic        [W-2:0] magnitude
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    if (sample == MOST_NEG) begin
      magnitude = {(W-1){1'b1}};
    end else if (sample[W-1]) begin
      magnitude = (W-1)'(-sample);
    end else begin
      magnitude = sample[W-2:0];
    end
  end

endmodule

// File: rtl/direction_vector_gen.sv
// -----------------------------------------------------------------------------
// direction_vector_gen
// Turns four microphone streams (+x, +y, -x, -y) into a stream of direction
// vectors. Each vector averages sample magnitudes over WINDOW accepted samples:
//   x = (sum|px| - sum|nx|) >>> log2(WINDOW),  y likewise from py/ny.
// A run emits NUM_VECTORS vectors and then signals done.
//
// Pipeline (accept at edge N):
//   N   : stage 1 registers saturated magnitudes
//   N+1 : stage 2 accumulates; on the last sample of a window snapshots sums
//   N+2 : stage 3 registers the vector and raises direction_valid_out
//
// Ports
//   clk_in              : clock, rising edge
//   rst_in              : asynchronous active-high reset
//   start_in            : one-cycle pulse, starts a run from IDLE
//   audio_valid_in      : qualifies mic_* this cycle
//   mic_px/py/nx/ny     : signed samples
//   direction           : {y, x}, held between valid pulses
//   direction_valid_out : one-cycle pulse qualifying direction
//   busy_out            : high while a run is in progress
//   done_out            : one-cycle pulse with the final vector of a run
// -----------------------------------------------------------------------------
module direction_vector_gen
  import localization_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int WINDOW       = 16,
  parameter int NUM_VECTORS  = 512,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           start_in,
  input  logic                           audio_valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_px,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_py,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_nx,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_ny,
  output logic        [DATA_WIDTH-1:0]   direction,
  output logic                           direction_valid_out,
  output logic                           busy_out,
  output logic                           done_out
);

  localparam int LOG2_WINDOW = $clog2(WINDOW);
  localparam int MAG_W       = SAMPLE_WIDTH - 1;
  // Sum of WINDOW magnitudes below 2^MAG_W each cannot exceed this width.
  localparam int ACC_W       = MAG_W + LOG2_WINDOW;
  localparam int VEC_W       = $clog2(NUM_VECTORS + 1);

  run_state_t state, state_next;

  logic                   accept;
  logic                   last_of_window;
  logic                   last_window;
  logic                   start_run;
  logic [LOG2_WINDOW-1:0] sample_cnt;
  logic [VEC_W-1:0]       vec_cnt;

  logic signed [SAMPLE_WIDTH-1:0] mic_in [NUM_MICS];
  logic [MAG_W-1:0]               mag_comb [NUM_MICS];
  logic [MAG_W-1:0]               mag_q [NUM_MICS];
  logic [ACC_W-1:0]               acc [NUM_MICS];
  logic [ACC_W-1:0]               snap [NUM_MICS];

  logic s1_valid, s1_last, s1_final;
  logic s2_valid, s2_final;

  logic signed [ACC_W:0]          diff_x, diff_y;
  logic signed [SAMPLE_WIDTH-1:0] vec_x, vec_y;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign accept         = (state == ST_RUN) && audio_valid_in;
  assign start_run      = (state == ST_IDLE) && start_in;
  assign last_of_window = (sample_cnt == LOG2_WINDOW'(WINDOW - 1));
  assign last_window    = (vec_cnt == VEC_W'(NUM_VECTORS - 1));
  assign busy_out       = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment first means every path drives state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start_in) state_next = ST_RUN;
      ST_RUN:   if (accept && last_of_window && last_window) state_next = ST_DRAIN;
      // done_out coincides with the final vector, so leaving on it drops
      // busy_out the cycle after that vector is presented.
      ST_DRAIN: if (done_out) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_cnt <= '0;
      vec_cnt    <= '0;
    end else if (start_run) begin
      sample_cnt <= '0;
      vec_cnt    <= '0;
    end else if (accept) begin
      // WINDOW is a power of two, so the counter wraps on its own.
      sample_cnt <= sample_cnt + LOG2_WINDOW'(1);
      if (last_of_window) begin
        vec_cnt <= last_window ? '0 : vec_cnt + VEC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: saturated magnitudes
  // ---------------------------------------------------------------------------
  assign mic_in[MIC_PX] = mic_px;
  assign mic_in[MIC_PY] = mic_py;
  assign mic_in[MIC_NX] = mic_nx;
  assign mic_in[MIC_NY] = mic_ny;

  for (genvar m = 0; m < NUM_MICS; m++) begin : g_abs
    abs_sat #(.W(SAMPLE_WIDTH)) u_abs_sat (
      .sample    (mic_in[m]),
      .magnitude (mag_comb[m])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_final <= 1'b0;
      for (int m = 0; m < NUM_MICS; m++) mag_q[m] <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && last_of_window;
      s1_final <= accept && last_of_window && last_window;
      if (accept) begin
        for (int m = 0; m < NUM_MICS; m++) mag_q[m] <= mag_comb[m];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate, snapshot on the last magnitude of each window
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid <= 1'b0;
      s2_final <= 1'b0;
      for (int m = 0; m < NUM_MICS; m++) begin
        acc[m]  <= '0;
        snap[m] <= '0;
      end
    end else begin
      s2_valid <= s1_valid && s1_last;
      s2_final <= s1_valid && s1_final;
      if (start_run) begin
        for (int m = 0; m < NUM_MICS; m++) acc[m] <= '0;
      end else if (s1_valid) begin
        for (int m = 0; m < NUM_MICS; m++) begin
          if (s1_last) begin
            // The closing magnitude goes into the snapshot; the next window's
            // first magnitude lands one edge later, so windows stay gap-free.
            snap[m] <= acc[m] + ACC_W'(mag_q[m]);
            acc[m]  <= '0;
          end else begin
            acc[m]  <= acc[m] + ACC_W'(mag_q[m]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: difference, scale by 1/WINDOW, register the vector
  // ---------------------------------------------------------------------------
  assign diff_x = $signed({1'b0, snap[MIC_PX]}) - $signed({1'b0, snap[MIC_NX]});
  assign diff_y = $signed({1'b0, snap[MIC_PY]}) - $signed({1'b0, snap[MIC_NY]});
  assign vec_x  = SAMPLE_WIDTH'(diff_x >>> LOG2_WINDOW);
  assign vec_y  = SAMPLE_WIDTH'(diff_y >>> LOG2_WINDOW);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      direction           <= '0;
      direction_valid_out <= 1'b0;
      done_out            <= 1'b0;
    end else begin
      direction_valid_out <= s2_valid;
      done_out            <= s2_valid && s2_final;
      if (s2_valid) begin
        direction <= DATA_WIDTH'({vec_y, vec_x});
      end
    end
  end

endmodule

// File: tb/tb_direction_vector_gen.sv
// -----------------------------------------------------------------------------
// tb_direction_vector_gen
// Self-checking bench for direction_vector_gen with WINDOW=4, NUM_VECTORS=2.
// A behavioural model tracks the run (accepting / busy), keeps running
// magnitude sums per window and schedules each expected vector two edges
// after its last accepted sample. A compare process checks every output on
// every falling edge; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_direction_vector_gen;

  localparam int SW  = 16;
  localparam int WIN = 4;
  localparam int NV  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        audio_valid_in = 1'b0;
  logic [SW-1:0] mic_px = '0, mic_py = '0, mic_nx = '0, mic_ny = '0;
  logic [31:0] direction;
  logic        direction_valid_out, busy_out, done_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  direction_vector_gen #(
    .SAMPLE_WIDTH (SW),
    .WINDOW       (WIN),
    .NUM_VECTORS  (NV),
    .DATA_WIDTH   (32)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .start_in            (start_in),
    .audio_valid_in      (audio_valid_in),
    .mic_px              (mic_px),
    .mic_py              (mic_py),
    .mic_nx              (mic_nx),
    .mic_ny              (mic_ny),
    .direction           (direction),
    .direction_valid_out (direction_valid_out),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [31:0] dir;
    bit          fin;
  } exp_t;

  exp_t        pend[$];
  int          cyc = 0;
  bit          m_busy = 0, m_accepting = 0;
  bit          m_valid = 0, m_done = 0;
  logic [31:0] m_dir = '0;
  int          n_acc = 0, win_cnt = 0;
  int          sum_px = 0, sum_py = 0, sum_nx = 0, sum_ny = 0;

  function automatic int mag_of(input logic [SW-1:0] s);
    int v;
    v = int'($signed(s));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit   start_ok;
    exp_t e;
    if (rst) begin
      pend.delete();
      m_busy = 0; m_accepting = 0; m_valid = 0; m_done = 0; m_dir = '0;
      n_acc = 0; win_cnt = 0; sum_px = 0; sum_py = 0; sum_nx = 0; sum_ny = 0;
    end else begin
      cyc++;
      start_ok = !m_busy && start_in;
      if (m_accepting && audio_valid_in) begin
        sum_px += mag_of(mic_px);
        sum_py += mag_of(mic_py);
        sum_nx += mag_of(mic_nx);
        sum_ny += mag_of(mic_ny);
        win_cnt++;
        n_acc++;
        if (win_cnt == WIN) begin
          e.due = cyc + 2;
          e.dir = {16'((sum_py - sum_ny) >>> 2), 16'((sum_px - sum_nx) >>> 2)};
          e.fin = (n_acc == WIN * NV);
          pend.push_back(e);
          win_cnt = 0; sum_px = 0; sum_py = 0; sum_nx = 0; sum_ny = 0;
          if (e.fin) m_accepting = 0;
        end
      end
      if (m_done) m_busy = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_valid = 1;
        m_dir   = pend[0].dir;
        m_done  = pend[0].fin;
        void'(pend.pop_front());
      end else begin
        m_valid = 0;
        m_done  = 0;
      end
      if (start_ok) begin
        m_busy = 1; m_accepting = 1; n_acc = 0; win_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(direction_valid_out), 32'(m_valid));
    check("done",  32'(done_out),            32'(m_done));
    check("busy",  32'(busy_out),            32'(m_busy));
    check("direction", direction, m_dir);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic drive_sample(input logic [SW-1:0] px, py, nx, ny);
    mic_px = px; mic_py = py; mic_nx = nx; mic_ny = ny;
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
  endtask

  function automatic logic [SW-1:0] rand_sample();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200 && m_busy; i++) tick();
    if (m_busy) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_direction", direction, 32'h0);
    check("reset_busy", 32'(busy_out), 32'h0);
    rst = 1'b0;
    tick();

    // Samples in IDLE are ignored.
    for (int i = 0; i < 3; i++) drive_sample(16'd500, 16'd0, 16'd0, 16'd0);
    tick();
    check("idle_no_valid", 32'(direction_valid_out), 32'h0);

    // Balanced x vector, with a stray start during RUN.
    pulse_start();
    drive_sample(16'd100, 16'd0, -16'sd40, 16'd0);
    start_in = 1'b1;
    drive_sample(16'd100, 16'd0, -16'sd40, 16'd0);
    start_in = 1'b0;
    drive_sample(16'd100, 16'd0, -16'sd40, 16'd0);
    drive_sample(16'd100, 16'd0, -16'sd40, 16'd0);
    tick();
    check("x_pre_valid", 32'(direction_valid_out), 32'h0);
    tick();
    check("x_valid", 32'(direction_valid_out), 32'h1);
    check("x_vector", direction, 32'h0000_003C);

    // Negative y, final window of the run.
    for (int i = 0; i < 4; i++) drive_sample(16'd0, 16'd0, 16'd0, 16'd200);
    tick(); tick();
    check("y_vector", direction, 32'hFF38_0000);
    check("y_done", 32'(done_out), 32'h1);
    tick();
    check("post_done_busy", 32'(busy_out), 32'h0);
    check("post_done_hold", direction, 32'hFF38_0000);
    drive_sample(16'd7, 16'd7, 16'd7, 16'd7);
    tick(); tick(); tick();
    check("ninth_ignored", direction, 32'hFF38_0000);

    // Saturation, then eight back-to-back samples across two runs.
    pulse_start();
    for (int i = 0; i < 4; i++) drive_sample(16'h8000, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    check("sat_vector", direction, 32'h0000_7FFF);
    for (int i = 0; i < 4; i++) drive_sample(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    wait_idle("sat_run");
    pulse_start();
    for (int i = 0; i < 8; i++) drive_sample(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    wait_idle("b2b_run");

    // Reset mid-run, then a fresh run.
    pulse_start();
    for (int i = 0; i < 3; i++) drive_sample(16'd1000, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_direction", direction, 32'h0);
    check("rst_valid", 32'(direction_valid_out), 32'h0);
    tick(); tick();
    rst = 1'b0;
    drive_sample(16'd900, 16'd0, 16'd0, 16'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) drive_sample(16'd8, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    check("fresh_vector", direction, 32'h0000_0008);
    for (int i = 0; i < 4; i++) drive_sample(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    wait_idle("fresh_run");

    // Randomized runs with gaps, stray starts and occasional resets.
    for (int r = 0; r < 25; r++) begin
      start_in = 1'b1;
      audio_valid_in = ($urandom_range(0, 1) == 1);
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 400; i++) begin
        audio_valid_in = ($urandom_range(0, 3) != 0);
        mic_px = rand_sample(); mic_py = rand_sample();
        mic_nx = rand_sample(); mic_ny = rand_sample();
        start_in = ($urandom_range(0, 15) == 0);
        if (r % 8 == 7 && i == 5) rst = 1'b1;
        tick();
        rst = 1'b0;
        if (!m_busy) break;
      end
      start_in = 1'b0;
      audio_valid_in = 1'b0;
      if (m_busy) check("random_run_timeout", 32'd1, 32'd0);
      repeat ($urandom_range(0, 3)) tick();
    end

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
